// File: rtl/basys3_keypad_scanner_pkg.sv
// ============================================================================
// Module      : basys3_keypad_scanner_pkg
// Description : Shared keypad types, key codes and the PMOD KYPD key map.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package basys3_keypad_scanner_pkg;

  typedef enum logic [1:0] {
    CLASS_NONE  = 2'd0,
    CLASS_ONE   = 2'd1,
    CLASS_MULTI = 2'd2
  } scan_class_e;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  // Indexed [row][col], matching the silkscreen of the PMOD KYPD.
  localparam logic [3:0] KEYMAP [0:3][0:3] = '{
    '{KEY_1, KEY_2, KEY_3, KEY_A},
    '{KEY_4, KEY_5, KEY_6, KEY_B},
    '{KEY_7, KEY_8, KEY_9, KEY_C},
    '{KEY_0, KEY_F, KEY_E, KEY_D}
  };

endpackage

`default_nettype wire

// File: rtl/basys3_keypad_scanner_if.sv
// ============================================================================
// Module      : basys3_keypad_scanner_if
// Description : Keypad pins plus the key-event outputs seen by the game FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface basys3_keypad_scanner_if;
  logic [3:0] rows_i;
  logic [3:0] cols_o;
  logic [3:0] key_o;
  logic       key_valid_o;
  logic       key_down_o;
  logic       multi_o;

  modport master (
    input  rows_i,
    output cols_o, key_o, key_valid_o, key_down_o, multi_o
  );

  modport slave (
    output rows_i,
    input  cols_o, key_o, key_valid_o, key_down_o, multi_o
  );
endinterface

`default_nettype wire

// File: rtl/basys3_keypad_scanner_debounce.sv
// ============================================================================
// Module      : keypad_debounce
// Description : Accepts a scan result after DEBOUNCE_SCANS identical scans.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_debounce
  import basys3_keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        eos_i,
  input  scan_class_e class_i,
  input  logic [3:0]  code_i,
  output logic [3:0]  key_o,
  output logic        key_valid_o,
  output logic        key_down_o
);

  localparam int                CNT_W     = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0]  C_CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

  scan_class_e      r_prev_class;
  logic [3:0]       r_prev_code;
  logic [CNT_W-1:0] r_stable_cnt;
  logic [3:0]       r_key;
  logic             r_valid;
  logic             r_down;

  logic             w_same;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_stable;
  logic             w_accept;
  logic             w_release;

  // Code is forced to zero upstream for non-ONE scans, so a plain compare works.
  always_comb begin
    w_same     = (class_i == r_prev_class) && (code_i == r_prev_code);
    w_cnt_next = CNT_W'(1);
    if (w_same) begin
      w_cnt_next = (r_stable_cnt == C_CNT_MAX) ? r_stable_cnt : r_stable_cnt + 1'b1;
    end
    w_stable  = (w_cnt_next == C_CNT_MAX);
    w_accept  = w_stable && (class_i == CLASS_ONE) && (!r_down || (code_i != r_key));
    w_release = w_stable && (class_i == CLASS_NONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prev_class <= CLASS_NONE;
      r_prev_code  <= 4'd0;
      r_stable_cnt <= '0;
      r_key        <= 4'd0;
      r_valid      <= 1'b0;
      r_down       <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (eos_i) begin
        r_prev_class <= class_i;
        r_prev_code  <= code_i;
        r_stable_cnt <= w_cnt_next;
        if (w_accept) begin
          r_key   <= code_i;
          r_down  <= 1'b1;
          r_valid <= 1'b1;
        end else if (w_release) begin
          r_down  <= 1'b0;
        end
      end
    end
  end

  assign key_o       = r_key;
  assign key_valid_o = r_valid;
  assign key_down_o  = r_down;

endmodule

`default_nettype wire

// File: rtl/basys3_keypad_scanner.sv
// ============================================================================
// Module      : basys3_keypad_scanner
// Description : PMOD KYPD 4x4 column scanner with debounced single-key events.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module basys3_keypad_scanner
  import basys3_keypad_scanner_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  basys3_keypad_scanner_if.master bus
);

  localparam int                   SETTLE_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0]  C_SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    COL_0 = 2'd0,
    COL_1 = 2'd1,
    COL_2 = 2'd2,
    COL_3 = 2'd3
  } col_state_e;

  col_state_e          r_col;
  col_state_e          w_col_next;
  logic [SETTLE_W-1:0] r_settle;
  logic [SETTLE_W-1:0] w_settle_next;
  logic [3:0]          r_rows_s1;
  logic [3:0]          r_rows_s2;
  logic [1:0]          r_cnt;
  logic [3:0]          r_code;
  logic                r_multi;
  logic                w_sample;
  logic                w_eos;
  logic [1:0]          w_col_idx;
  logic [1:0]          w_cnt;
  logic [3:0]          w_code;
  scan_class_e         w_class;
  logic [3:0]          w_class_code;
  logic [3:0]          w_key;
  logic                w_key_valid;
  logic                w_key_down;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rows_s1 <= 4'b1111;
      r_rows_s2 <= 4'b1111;
    end else begin
      r_rows_s1 <= bus.rows_i;
      r_rows_s2 <= r_rows_s1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_col    <= COL_0;
      r_settle <= '0;
    end else begin
      r_col    <= w_col_next;
      r_settle <= w_settle_next;
    end
  end

  always_comb begin
    w_sample      = (r_settle == C_SETTLE_LAST);
    w_eos         = w_sample && (r_col == COL_3);
    w_settle_next = w_sample ? '0 : r_settle + 1'b1;
    w_col_next    = r_col;
    if (w_sample) begin
      case (r_col)
        COL_0:   w_col_next = COL_1;
        COL_1:   w_col_next = COL_2;
        COL_2:   w_col_next = COL_3;
        default: w_col_next = COL_0;
      endcase
    end
  end

  // Column 0 starts a fresh scan, so it ignores whatever the accumulators hold.
  always_comb begin
    w_col_idx = r_col;
    w_cnt     = (r_col == COL_0) ? 2'd0 : r_cnt;
    w_code    = (r_col == COL_0) ? 4'd0 : r_code;
    for (int r = 0; r < 4; r++) begin
      if (!r_rows_s2[r]) begin
        if (w_cnt != 2'd2) begin
          w_cnt = w_cnt + 2'd1;
        end
        w_code = KEYMAP[r][w_col_idx];
      end
    end
    w_class      = CLASS_NONE;
    w_class_code = 4'd0;
    if (w_cnt == 2'd2) begin
      w_class = CLASS_MULTI;
    end else if (w_cnt == 2'd1) begin
      w_class      = CLASS_ONE;
      w_class_code = w_code;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt   <= 2'd0;
      r_code  <= 4'd0;
      r_multi <= 1'b0;
    end else begin
      if (w_sample) begin
        r_cnt  <= w_cnt;
        r_code <= w_code;
      end
      if (w_eos) begin
        r_multi <= (w_class == CLASS_MULTI);
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .eos_i       (w_eos),
    .class_i     (w_class),
    .code_i      (w_class_code),
    .key_o       (w_key),
    .key_valid_o (w_key_valid),
    .key_down_o  (w_key_down)
  );

  assign bus.cols_o      = ~(4'b0001 << w_col_idx);
  assign bus.key_o       = w_key;
  assign bus.key_valid_o = w_key_valid;
  assign bus.key_down_o  = w_key_down;
  assign bus.multi_o     = r_multi;

endmodule

`default_nettype wire

// File: tb/tb_basys3_keypad_scanner.sv
// ============================================================================
// Module      : tb_basys3_keypad_scanner
// Description : Directed keypad scenarios with a queue of expected key events.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_basys3_keypad_scanner;

  localparam int C_SCAN = 16;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [3:0] pressed [4];
  logic [3:0] exp_q [$];
  int         checks = 0;
  int         errors = 0;

  basys3_keypad_scanner_if bus ();

  basys3_keypad_scanner #(
    .SETTLE_CYCLES  (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Passive keypad: a row reads low when a pressed key sits on a driven-low column.
  always_comb begin
    bus.rows_i = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      bus.rows_i[r] = ~|(pressed[r] & ~bus.cols_o);
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
  endtask

  task automatic expect_key(input string tag, input logic [3:0] code);
    exp_q.push_back(code);
    wait_cycles(6 * C_SCAN);
    check(tag, 8'(exp_q.size()), 8'd0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (rst_ni === 1'b1 && bus.key_valid_o === 1'b1) begin
      logic [3:0] exp_code;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pulse: observed key=%0h expected no pulse", bus.key_o);
      end
      if (exp_q.size() != 0) begin
        exp_code = exp_q.pop_front();
        checks++;
        assert (bus.key_o === exp_code) else begin
          errors++;
          $error("FAIL pulse_key: observed=%0h expected=%0h", bus.key_o, exp_code);
        end
        checks++;
        assert (bus.key_down_o === 1'b1) else begin
          errors++;
          $error("FAIL pulse_down: observed=%0b expected=1", bus.key_down_o);
        end
      end
    end
  end

  initial begin
    logic [3:0] col_seq [4];
    logic       found;
    col_seq[0] = 4'b1110;
    col_seq[1] = 4'b1101;
    col_seq[2] = 4'b1011;
    col_seq[3] = 4'b0111;
    release_all();
    rst_ni = 1'b0;

    // Reset state, then the idle column rotation.
    wait_cycles(3);
    check("reset_cols", 8'(bus.cols_o), 8'b1110);
    check("reset_outs", {bus.key_o, bus.key_valid_o, bus.key_down_o, bus.multi_o}, 8'd0);
    rst_ni = 1'b1;
    #1;
    for (int i = 0; i < 2 * C_SCAN; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("idle_cols_%0d", i), 8'(bus.cols_o), 8'(col_seq[(i / 4) % 4]));
      check($sformatf("idle_outs_%0d", i),
            {bus.key_o, bus.key_valid_o, bus.key_down_o, bus.multi_o}, 8'd0);
    end

    // '6' pressed and held: one event, then nothing for ten scans.
    pressed[1][2] = 1'b1;
    expect_key("press_6", 4'h6);
    wait_cycles(10 * C_SCAN);
    check("hold_6_down", 8'(bus.key_down_o), 8'd1);
    check("hold_6_key", 8'(bus.key_o), 8'h6);

    // Add '1' while '6' is down: multi flagged, accepted key untouched.
    pressed[0][0] = 1'b1;
    wait_cycles(4 * C_SCAN);
    check("multi_flag", 8'(bus.multi_o), 8'd1);
    check("multi_key", 8'(bus.key_o), 8'h6);
    check("multi_down", 8'(bus.key_down_o), 8'd1);

    // Release everything: key_down drops, no event.
    release_all();
    wait_cycles(5 * C_SCAN);
    check("release_down", 8'(bus.key_down_o), 8'd0);
    check("release_multi", 8'(bus.multi_o), 8'd0);
    check("release_key", 8'(bus.key_o), 8'h6);

    // Bouncing '7' must not produce an event; steady '7' must.
    for (int i = 0; i < 8; i++) begin
      pressed[2][0] = ~pressed[2][0];
      wait_cycles(5);
    end
    pressed[2][0] = 1'b1;
    expect_key("press_7", 4'h7);

    release_all();
    wait_cycles(5 * C_SCAN);
    check("release7_down", 8'(bus.key_down_o), 8'd0);

    // '0', then slide straight to 'D'.
    pressed[3][0] = 1'b1;
    expect_key("press_0", 4'h0);
    pressed[3][0] = 1'b0;
    pressed[3][3] = 1'b1;
    expect_key("slide_D", 4'hD);

    // '5' down, then asynchronous reset in the middle of column 2.
    pressed[3][3] = 1'b0;
    pressed[1][1] = 1'b1;
    expect_key("press_5", 4'h5);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = (bus.cols_o == 4'b1011);
    end
    check("find_col2", 8'(found), 8'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("async_cols", 8'(bus.cols_o), 8'b1110);
    check("async_outs", {bus.key_o, bus.key_valid_o, bus.key_down_o, bus.multi_o}, 8'd0);
    wait_cycles(2);
    rst_ni = 1'b1;
    exp_q.push_back(4'h5);
    wait_cycles(40);
    check("no_early_pulse", 8'(exp_q.size()), 8'd1);
    check("no_early_down", 8'(bus.key_down_o), 8'd0);
    wait_cycles(56);
    check("post_reset_5", 8'(exp_q.size()), 8'd0);
    exp_q.delete();
    check("post_reset_key", 8'(bus.key_o), 8'h5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
